// File: rtl/alu_result_stage.sv
// Registered ALU result stage with flag derivation and a two-entry skid buffer.
// Optional performance counters are enabled by ALU_RESULT_STAGE_PERF_EN.
module alu_result_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_result,
    input  logic             in_carryout,
    input  logic             in_overflow,
    input  logic             in_is_slt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_zero,
    output logic             out_negative,
    output logic             out_carryout,
    output logic             out_overflow
`ifdef ALU_RESULT_STAGE_PERF_EN
    ,
    output logic [31:0]      perf_accepted,
    output logic [31:0]      perf_stalled
`endif
);

    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic             zero;
        logic             negative;
        logic             carry;
        logic             ovf;
    } entry_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    localparam entry_t RST_E = '{
        result:   '0,
        zero:     1'b1,
        negative: 1'b0,
        carry:    1'b0,
        ovf:      1'b0
    };

    state_t state_q, state_d;
    entry_t main_q, main_d;
    entry_t skid_q, skid_d;
    entry_t new_e;
    logic   in_ready_q;
    logic   out_valid_q;
    logic   in_fire;
    logic   out_fire;

    assign in_fire  = in_valid & in_ready_q;
    assign out_fire = out_valid_q & out_ready;

    // Flags travel with the entry; SLT results carry no meaningful carry/ovf.
    always_comb begin
        new_e          = RST_E;
        new_e.result   = in_result;
        new_e.zero     = (in_result == '0);
        new_e.negative = in_result[WIDTH-1];
        new_e.carry    = in_carryout & ~in_is_slt;
        new_e.ovf      = in_overflow & ~in_is_slt;
    end

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        unique case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    main_d  = new_e;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (in_fire && out_fire) begin
                    main_d = new_e;
                end else if (out_fire) begin
                    state_d = EMPTY;
                end else if (in_fire) begin
                    skid_d  = new_e;
                    state_d = FULL;
                end
            end
            FULL: begin
                if (out_fire) begin
                    main_d  = skid_q;
                    skid_d  = RST_E;
                    state_d = BUSY;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    // Handshake outputs are registered copies of the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            main_q      <= RST_E;
            skid_q      <= RST_E;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            in_ready_q  <= (state_d != FULL);
            out_valid_q <= (state_d != EMPTY);
        end
    end

    assign in_ready     = in_ready_q;
    assign out_valid    = out_valid_q;
    assign out_result   = main_q.result;
    assign out_zero     = main_q.zero;
    assign out_negative = main_q.negative;
    assign out_carryout = main_q.carry;
    assign out_overflow = main_q.ovf;

`ifdef ALU_RESULT_STAGE_PERF_EN
    logic [31:0] acc_q;
    logic [31:0] stall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q   <= '0;
            stall_q <= '0;
        end else begin
            if (in_fire && (acc_q != '1)) begin
                acc_q <= acc_q + 32'd1;
            end
            if (out_valid_q && !out_ready && (stall_q != '1)) begin
                stall_q <= stall_q + 32'd1;
            end
        end
    end

    assign perf_accepted = acc_q;
    assign perf_stalled  = stall_q;
`endif

endmodule
